// File: rtl/kernel_job_agent.sv
// rtl/kernel_job_agent.sv - kernel-slot responder for scheduler dispatch/completion handshake
//
// Accepts one job descriptor while idle, launches the kernel, waits for its
// finish pulse, then holds a {pasid, status} completion word until the
// scheduler takes it. Tracks completed jobs and the RUN duration of the last job.
//
// Optional feature macro: KERNEL_TIMEOUT_EN (RUN watchdog with kernel_abort).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   engine_start/engine_data        dispatch strobe and descriptor
//   engine_ready                    agent idle, can take a job
//   complete_ready/complete_accept  completion handshake
//   complete_data                   {pasid, return_code}
//   kernel_start/src/dst/len        kernel launch pulse and command fields
//   kernel_done/kernel_status       kernel finish pulse and return code
//   kernel_abort                    watchdog abort pulse (0 without the macro)
//   jobs_done, last_cycles          completed-job count, last job RUN cycles
module kernel_job_agent #(
    parameter int          HOST_DWIDTH    = 1024,
    parameter int          HOST_AWIDTH    = 64,
    parameter int          PASID_WIDTH    = 9,
    parameter int          RETURN_WIDTH   = 41,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    engine_start,
    input  logic [HOST_DWIDTH-1:0]  engine_data,
    output logic                    engine_ready,
    output logic                    complete_ready,
    input  logic                    complete_accept,
    output logic [RETURN_WIDTH-1:0] complete_data,
    output logic                    kernel_start,
    output logic [HOST_AWIDTH-1:0]  kernel_src,
    output logic [HOST_AWIDTH-1:0]  kernel_dst,
    output logic [31:0]             kernel_len,
    input  logic                    kernel_done,
    input  logic [31:0]             kernel_status,
    output logic                    kernel_abort,
    output logic [31:0]             jobs_done,
    output logic [31:0]             last_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_CMPL
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PASID_WIDTH-1:0] pasid_q;
    logic [31:0]            status_q;
    logic [31:0]            cycle_cnt;
    logic [31:0]            cnt_inc;
    logic                   timeout_hit;
    logic                   unused_bits;

    // cnt_inc counts the current RUN cycle itself, so a done pulse N cycles
    // after kernel_start reports last_cycles = N.
    assign cnt_inc = (cycle_cnt == 32'hFFFF_FFFF) ? cycle_cnt : cycle_cnt + 32'd1;

`ifdef KERNEL_TIMEOUT_EN
    // A done pulse in the timeout cycle takes priority over the watchdog.
    assign timeout_hit = (state == S_RUN) && !kernel_done && (cnt_inc == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kernel_abort <= 1'b0;
        end else begin
            kernel_abort <= timeout_hit;
        end
    end

    assign unused_bits = ^{engine_data[HOST_DWIDTH-1:224], engine_data[63:PASID_WIDTH]};
`else
    assign timeout_hit  = 1'b0;
    assign kernel_abort = 1'b0;
    assign unused_bits  = ^{engine_data[HOST_DWIDTH-1:224], engine_data[63:PASID_WIDTH],
                            (TIMEOUT_CYCLES == 32'd0)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (engine_start) state_next = S_START;
            S_START: state_next = S_RUN;
            S_RUN:   if (kernel_done || timeout_hit) state_next = S_CMPL;
            S_CMPL:  if (complete_accept) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pasid_q     <= '0;
            status_q    <= '0;
            cycle_cnt   <= '0;
            last_cycles <= '0;
            jobs_done   <= '0;
            kernel_src  <= '0;
            kernel_dst  <= '0;
            kernel_len  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (engine_start) begin
                        pasid_q    <= engine_data[PASID_WIDTH-1:0];
                        kernel_src <= engine_data[64 +: HOST_AWIDTH];
                        kernel_dst <= engine_data[128 +: HOST_AWIDTH];
                        kernel_len <= engine_data[223:192];
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cnt_inc;
                    if (kernel_done) begin
                        status_q    <= kernel_status;
                        last_cycles <= cnt_inc;
                    end else if (timeout_hit) begin
                        status_q    <= 32'hDEAD_0001;
                        last_cycles <= TIMEOUT_CYCLES;
                    end
                end
                S_CMPL: begin
                    if (complete_accept) begin
                        jobs_done <= jobs_done + 32'd1;
                        cycle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign engine_ready   = (state == S_IDLE);
    assign kernel_start   = (state == S_START);
    assign complete_ready = (state == S_CMPL);
    assign complete_data  = {pasid_q, status_q};

endmodule
